bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It produces packed BCD digits that feed the team's BCD validation and display path. Conversion is started by a one-cycle start request, runs for WIDTH cycles, and ends with a done pulse. Values that do not fit in DIGITS decimal digits are flagged and replaced by an all-ones (non-BCD) pattern, so downstream BCD filters reject them.

Parameters:
WIDTH, 8, bit width of the binary input (1..16)
DIGITS, 3, number of BCD output digits (1..5)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
start  input  1  conversion request; sampled only in IDLE
in  input  WIDTH  unsigned binary value; captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; out/error are valid from this cycle on
out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0]
error  output  1  high when in > 10^DIGITS - 1

Behaviour:
- Reset: one clock, synchronous, active-high (fixed). On a reset edge: state=IDLE, busy=0, done=0, out=0, error=0, and the internal shift register and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge, capture in into the binary shift register, clear the BCD accumulator and overflow bit, set count=0, and go to SHIFT. busy=1 from the next cycle. If start=0, stay in IDLE.
- SHIFT: on each edge, any accumulator digit >= 5 first gets +3, then {overflow, accumulator, binary} shifts left by 1. The overflow bit is sticky: it ORs in the bit shifted out of the top digit. count increments. On the edge that completes shift number WIDTH, go to DONE.
- DONE is a single cycle: done=1 and busy=0. On the edge entering DONE, out and error are loaded:
  - overflow=0: out = accumulator, error=0.
  - overflow=1: out = all ones (every digit 4'hF), error=1.
- After DONE, go to IDLE. start is ignored during DONE.
- Latency: start accepted at edge E0, done high in the cycle after edge E_WIDTH (WIDTH+1 edges from acceptance to the done cycle). Throughput is one conversion per WIDTH+2 cycles.
- out and error hold their last result until the next DONE. They do not change during SHIFT.
- start while busy or in DONE: ignored. It is not queued and does not restart the conversion. in may change freely after the accepting edge.
- Reset mid-conversion: abort immediately and clear all outputs. No done pulse is produced.
- Reset and start at the same edge: reset wins, and start is not accepted.
- Add-3 is applied per 4-bit digit, modulo 16. The add-3 check uses the digit value before the shift of the same cycle.
- done is never high together with busy.

Test Plan:
1. WIDTH=8, DIGITS=3, in=0, start pulse -> busy high for 8 cycles, then done=1, out=12'h000, error=0.
2. WIDTH=8, DIGITS=3, sweep in=0..255 with a start for each value and wait for done -> out equals the decimal digits every time (e.g. 255 -> 12'h255, 99 -> 12'h099, 10 -> 12'h010), error=0 throughout.
3. WIDTH=8, DIGITS=2, in=99 -> out=8'h99, error=0; in=100 -> out=8'hFF, error=1; in=255 -> out=8'hFF, error=1.
4. Start with in=200, then pulse start with in=17 during SHIFT and again during DONE -> a single done pulse, out=12'h200, and no second conversion follows.
5. Start with in=123, assert reset on the 4th SHIFT cycle -> next cycle busy=0, done=0, out=0, error=0, and no later done. A subsequent start with in=45 -> out=12'h045.
6. Back-to-back: hold start high continuously with in=7 -> a conversion is accepted every WIDTH+2 cycles, each done pulse is one cycle wide, out=12'h007.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with overflow flag
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   start  conversion request, honoured only in IDLE
//   in     unsigned binary operand, captured on the accepting edge
//   busy   high while shifting
//   done   one-cycle pulse; out/error valid from this cycle on
//   out    packed BCD result (digit 0 in [3:0]); all 4'hF on overflow
//   error  high when the value needs more than DIGITS decimal digits
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   out,
    output logic                  error
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0]    bin;
    logic [4*DIGITS-1:0] acc, adj, acc_n;
    logic                ovf, ovf_n, last;
    logic [CW-1:0]       count;
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g+:4] = acc[4*g+:4] >= 4'd5 ? acc[4*g+:4] + 4'd3 : acc[4*g+:4];
    end
    // Shift {ovf, acc, bin} left by one; the bit leaving the top digit is folded into the sticky overflow.
    assign acc_n = {adj[4*DIGITS-2:0], bin[WIDTH-1]};
    assign ovf_n = ovf | adj[4*DIGITS-1];
    assign last  = count == CW'(WIDTH - 1);
    assign busy  = state == SHIFT;
    assign done  = state == DONE;
    always_comb begin
        state_n = IDLE;
        state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bin   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            out   <= '0;
            error <= 1'b0;
        end else if (state == IDLE && start) begin
            bin   <= in;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (state == SHIFT) begin
            bin   <= bin << 1;
            acc   <= acc_n;
            ovf   <= ovf_n;
            count <= count + CW'(1);
            // Results are published from the post-shift values on the final shift edge.
            if (last) begin
                out   <= ovf_n ? '1 : acc_n;
                error <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq (3-digit and 2-digit instances)
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic        busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [11:0] out_a;
    logic [7:0]  out_b;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in(in_a),
        .busy(busy_a), .done(done_a), .out(out_a), .error(error_a)
    );
    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in(in_b),
        .busy(busy_b), .done(done_b), .out(out_b), .error(error_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // One full conversion on dut_a (sel=0) or dut_b (sel=1), checking latency, hold and result.
    task automatic run(input bit sel, input logic [7:0] v, input logic [11:0] eo, input logic ee);
        logic [11:0] prev;
        int k;
        prev = sel ? {4'h0, out_b} : out_a;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; in_b = v; end
        else     begin start_a = 1'b1; in_a = v; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        chk("busy_after_start", sel ? busy_b : busy_a, 1);
        chk("out_hold", sel ? {4'h0, out_b} : out_a, prev);
        k = 1;
        while (!(sel ? done_b : done_a) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, 9);
        chk("busy_in_done", sel ? busy_b : busy_a, 0);
        chk("out", sel ? {4'h0, out_b} : out_a, eo);
        chk("error", sel ? error_b : error_a, ee);
    endtask

    initial begin
        int k, n, nd, last, wide, overlap;
        bit pd;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_out", out_a, 0);
        chk("rst_error", error_a, 0);
        chk("rst_out_b", out_b, 0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) run(0, 8'(i), bcd(i), 1'b0);

        run(1, 8'd99, 12'h099, 1'b0);
        run(1, 8'd100, 12'h0FF, 1'b1);
        run(1, 8'd255, 12'h0FF, 1'b1);
        run(1, 8'd42, 12'h042, 1'b0);

        @(negedge clk);
        start_a = 1'b1; in_a = 8'd200;
        @(negedge clk);
        in_a = 8'd17;
        @(negedge clk);
        start_a = 1'b0;
        k = 2;
        while (!done_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ign_latency", k, 9);
        chk("ign_out", out_a, 12'h200);
        chk("ign_error", error_a, 0);
        start_a = 1'b1; in_a = 8'd17;
        @(negedge clk);
        start_a = 1'b0;
        chk("ign_done_start", busy_a, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a || busy_a) nd++;
        end
        chk("ign_no_restart", nd, 0);
        chk("ign_out_kept", out_a, 12'h200);

        @(negedge clk);
        start_a = 1'b1; in_a = 8'd123;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_out", out_a, 0);
        chk("abort_error", error_a, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        chk("abort_no_done", nd, 0);
        run(0, 8'd45, 12'h045, 1'b0);

        @(negedge clk);
        reset = 1'b1; start_a = 1'b1; in_a = 8'd9;
        @(negedge clk);
        reset = 1'b0; start_a = 1'b0;
        chk("rst_beats_start", busy_a, 0);
        chk("rst_beats_start_out", out_a, 0);

        @(negedge clk);
        start_a = 1'b1; in_a = 8'd7;
        n = 0; last = 0; wide = 0; overlap = 0; pd = 1'b0;
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            if (done_a && busy_a) overlap++;
            if (done_a) begin
                if (pd) wide++;
                if (last > 0) chk("b2b_interval", t - last, 10);
                else          chk("b2b_first", t, 9);
                chk("b2b_out", out_a, 12'h007);
                last = t;
                n++;
            end
            pd = done_a;
        end
        start_a = 1'b0;
        chk("b2b_pulses", n, 4);
        chk("b2b_width", wide, 0);
        chk("b2b_overlap", overlap, 0);
        k = 0;
        while ((busy_a || done_a) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_idle", busy_a | done_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
